axi_sram_ctrl: RTL and testbench
================================

// Module: axi_sram_ctrl
// PURPOSE
//  AXI4 slave controller between the sr_cpu_axi master port and a single-port synchronous SRAM macro.
//  Converts AW/W/B and AR/R bursts into per-beat SRAM accesses with byte enables.
//  Handles one transaction at a time, with a fair choice between a write and a read.
//  Replaces the ad-hoc slave logic in front of the coupled RAM array.
// PARAMETERS
//  MEM_ADDR_WIDTH  10  SRAM word-address width (depth = 2**MEM_ADDR_WIDTH words)
//  DATA_BYTES       4  bytes per beat/SRAM word; must equal axi_type.svh data width / 8
// PORTS
//  clk_i        in   1                 clock, all logic on rising edge
//  rst_i        in   1                 synchronous reset, active-high
//  in_mosi_i    in   axi_mosi_t        AW/W/AR channels and bready/rready from master
//  in_miso_o    out  axi_miso_t        awready/wready/arready plus B and R channels to master
//  mem_en_o     out  1                 SRAM access enable
//  mem_we_o     out  DATA_BYTES        SRAM byte write enables (0 = read)
//  mem_addr_o   out  MEM_ADDR_WIDTH    SRAM word address = axaddr >> log2(DATA_BYTES)
//  mem_wdata_o  out  8*DATA_BYTES      SRAM write data
//  mem_rdata_i  in   8*DATA_BYTES      SRAM read data, valid the cycle after mem_en_o with we=0
// BEHAVIOUR
//  Reset:
//  - All ready/valid outputs are 0; mem_en_o=0 and mem_we_o=0.
//  - State is IDLE and the arbiter priority pointer is set to WRITE.
//  - Reset mid-burst aborts the transaction: no B/R response, no further SRAM access.
//  FSM states: IDLE, WR_DATA, WR_RESP, RD_REQ, RD_DATA.
//  IDLE:
//  - awready/arready are high only in IDLE, and only for the granted channel. At most one handshake per cycle.
//  - If both aw.valid and ar.valid are high, grant the pointer side; the pointer then flips to the other side.
//  - On grant, capture id, addr, len, burst, and clear the beat counter.
//  - AW grant goes to WR_DATA. AR grant goes to RD_REQ.
//  WR_DATA:
//  - wready=1. On each W handshake, drive mem_en_o=1 and mem_we_o=wstrb at the current address, then advance the address.
//  - On beat len, go to WR_RESP.
//  - If wlast does not match beat==len, latch SLVERR. Beat counting always follows len.
//  WR_RESP:
//  - bvalid=1 with bid=captured id.
//  - bresp = OKAY(00), or SLVERR(10) if any error was latched.
//  - bvalid and its fields are held stable until bready, then go to IDLE.
//  RD_REQ:
//  - Drive mem_en_o=1, mem_we_o=0 for one cycle, then go to RD_DATA.
//  RD_DATA:
//  - Register mem_rdata_i into the R output register. rvalid=1, rid=captured id, rlast=(beat==len).
//  - R fields are held stable until rready.
//  - On handshake: if last, go to IDLE; otherwise advance the address and go to RD_REQ.
//  - Throughput is 1 beat per 2 cycles.
//  Latency:
//  - Write: AW accepted at cycle 0; first W accepted at cycle 1 at the earliest; bvalid the cycle after the last W.
//  - Read: AR accepted at cycle 0; SRAM read at cycle 1; rvalid at cycle 2.
//  Address generation (byte address, step DATA_BYTES):
//  - FIXED(00): address is constant for every beat.
//  - INCR(01): address increments by DATA_BYTES per beat. It wraps modulo 2**(MEM_ADDR_WIDTH+log2 DATA_BYTES), with no error.
//  - WRAP(10): wrap boundary = (len+1)*DATA_BYTES, and len must be 1, 3, 7 or 15. Any other len is treated as INCR with SLVERR.
//  - Reserved (11): treated as INCR with SLVERR.
//  Range check:
//  - Any address bit at or above MEM_ADDR_WIDTH+log2(DATA_BYTES) set on a beat marks that beat out of range.
//  - Out-of-range write: write suppressed (mem_we_o=0) and SLVERR latched.
//  - Out-of-range read: SRAM is not accessed; rdata=0 and rresp=SLVERR for that beat.
//  - Unaligned start addresses are aligned down; the low address bits are ignored.
// TESTING
//  - Single write then read: AW 0x010 len0 wdata 0xDEADBEEF wstrb F, then AR 0x010.
//    Required: bresp 00; rdata 0xDEADBEEF, rlast=1, rresp 00; rvalid 2 cycles after AR handshake.
//  - INCR len3 write at 0x020 with data 1..4, wstrb 0x3 on beat 2; read back after preload 0xFFFFFFFF.
//    Required: reads return 1, 2, 0xFFFF0003, 4, with rlast on beat 3 only.
//  - WRAP len3 read at 0x00C. Required: mem_addr_o sequence 3, 0, 1, 2.
//    WRAP len2 read. Required: incrementing addresses and rresp SLVERR.
//  - aw.valid and ar.valid together straight after reset. Required: write granted first, then read.
//    Repeated together a second time: read granted first.
//  - Hold rready=0 for 5 cycles on beat 1 of a len1 read. Required: rdata, rid and rlast stable; no mem_en_o pulse in that window.
//  - Write to out-of-range 0x1000_0000: required bresp SLVERR, mem_we_o stays 0.
//    Assert rst_i during beat 2 of a len3 write: required bvalid never asserted, FSM back in IDLE.

Source files
------------

// File: rtl/axi_sram_ctrl_if.sv
// axi_sram_ctrl_if: AXI4 channel bundle between a bus master and the SRAM controller
interface axi_sram_ctrl_if #(
    parameter int ID_W       = 4,
    parameter int ADDR_W     = 32,
    parameter int DATA_BYTES = 4
);
    logic [ID_W-1:0]         awid;
    logic [ADDR_W-1:0]       awaddr;
    logic [7:0]              awlen;
    logic [1:0]              awburst;
    logic                    awvalid;
    logic                    awready;
    logic [8*DATA_BYTES-1:0] wdata;
    logic [DATA_BYTES-1:0]   wstrb;
    logic                    wlast;
    logic                    wvalid;
    logic                    wready;
    logic [ID_W-1:0]         bid;
    logic [1:0]              bresp;
    logic                    bvalid;
    logic                    bready;
    logic [ID_W-1:0]         arid;
    logic [ADDR_W-1:0]       araddr;
    logic [7:0]              arlen;
    logic [1:0]              arburst;
    logic                    arvalid;
    logic                    arready;
    logic [ID_W-1:0]         rid;
    logic [8*DATA_BYTES-1:0] rdata;
    logic [1:0]              rresp;
    logic                    rlast;
    logic                    rvalid;
    logic                    rready;

    modport master (
        output awid, awaddr, awlen, awburst, awvalid, wdata, wstrb, wlast, wvalid, bready,
               arid, araddr, arlen, arburst, arvalid, rready,
        input  awready, wready, bid, bresp, bvalid, arready, rid, rdata, rresp, rlast, rvalid
    );

    modport slave (
        input  awid, awaddr, awlen, awburst, awvalid, wdata, wstrb, wlast, wvalid, bready,
               arid, araddr, arlen, arburst, arvalid, rready,
        output awready, wready, bid, bresp, bvalid, arready, rid, rdata, rresp, rlast, rvalid
    );
endinterface

// File: rtl/axi_sram_ctrl.sv
// axi_sram_ctrl: AXI4 slave turning write/read bursts into per-beat single-port SRAM accesses
module axi_sram_ctrl #(
    parameter int MEM_ADDR_WIDTH = 10,
    parameter int DATA_BYTES     = 4,
    parameter int ID_W           = 4,
    parameter int ADDR_W         = 32
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    axi_sram_ctrl_if.slave            axi,
    output logic                      mem_en_o,
    output logic [DATA_BYTES-1:0]     mem_we_o,
    output logic [MEM_ADDR_WIDTH-1:0] mem_addr_o,
    output logic [8*DATA_BYTES-1:0]   mem_wdata_o,
    input  logic [8*DATA_BYTES-1:0]   mem_rdata_i
);
    localparam int LSB = $clog2(DATA_BYTES);
    localparam int RW  = MEM_ADDR_WIDTH + LSB;
    localparam logic [1:0] FIXED  = 2'b00;
    localparam logic [1:0] INCR   = 2'b01;
    localparam logic [1:0] WRAP   = 2'b10;
    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;

    typedef enum logic [2:0] {IDLE, WR_DATA, WR_RESP, RD_REQ, RD_DATA} state_t;

    state_t                  state_q, state_d;
    logic                    prio_wr_q, prio_wr_d;
    logic [ID_W-1:0]         id_q, id_d;
    logic [ADDR_W-1:0]       addr_q, addr_d;
    logic [7:0]              len_q, len_d;
    logic [7:0]              beat_q, beat_d;
    logic [1:0]              burst_q, burst_d;
    logic                    err_q, err_d;
    logic                    fresh_q, fresh_d;
    logic [8*DATA_BYTES-1:0] rdata_q, rdata_d;

    logic                    oor;
    logic                    last;
    logic                    grant_w;
    logic                    grant_r;
    logic                    wrap_ok;
    logic [7:0]              sel_len;
    logic [1:0]              sel_burst;
    logic [ADDR_W-1:0]       sel_addr;
    logic [ADDR_W-1:0]       wrap_mask;
    logic [ADDR_W-1:0]       next_addr;
    logic [8*DATA_BYTES-1:0] rd_now;

    // Beat context: range check, last beat, read data with out-of-range beats forced to zero
    assign oor    = |addr_q[ADDR_W-1:RW];
    assign last   = beat_q == len_q;
    assign rd_now = oor ? '0 : mem_rdata_i;

    // Fair arbiter: on contention the pointer side wins; nothing is accepted while in reset
    assign grant_w = !rst_i && state_q == IDLE && axi.awvalid && (!axi.arvalid || prio_wr_q);
    assign grant_r = !rst_i && state_q == IDLE && axi.arvalid && (!axi.awvalid || !prio_wr_q);

    assign sel_len   = grant_w ? axi.awlen : axi.arlen;
    assign sel_burst = grant_w ? axi.awburst : axi.arburst;
    assign sel_addr  = (grant_w ? axi.awaddr : axi.araddr) & ~ADDR_W'(DATA_BYTES - 1);
    assign wrap_ok   = sel_len inside {8'd1, 8'd3, 8'd7, 8'd15};

    // INCR rolls over inside the SRAM byte space and never touches the out-of-range bits
    assign wrap_mask = ((ADDR_W'(len_q) + ADDR_W'(1)) << LSB) - ADDR_W'(1);
    assign next_addr = burst_q == FIXED ? addr_q :
                       burst_q == WRAP  ? (addr_q & ~wrap_mask) | ((addr_q + ADDR_W'(DATA_BYTES)) & wrap_mask) :
                                          {addr_q[ADDR_W-1:RW], addr_q[RW-1:0] + RW'(DATA_BYTES)};

    assign mem_addr_o  = addr_q[RW-1:LSB];
    assign mem_wdata_o = axi.wdata;

    assign axi.awready = grant_w;
    assign axi.arready = grant_r;
    assign axi.wready  = state_q == WR_DATA;
    assign axi.bvalid  = state_q == WR_RESP;
    assign axi.bid     = id_q;
    assign axi.bresp   = err_q ? SLVERR : OKAY;
    assign axi.rvalid  = state_q == RD_DATA;
    assign axi.rid     = id_q;
    assign axi.rlast   = last;
    assign axi.rresp   = (err_q || oor) ? SLVERR : OKAY;
    // SRAM data is passed through on the first R cycle and held from the register afterwards
    assign axi.rdata   = fresh_q ? rd_now : rdata_q;

    // Next-state, burst capture and SRAM strobe decode
    always_comb begin
        state_d   = state_q;
        prio_wr_d = prio_wr_q;
        id_d      = id_q;
        addr_d    = addr_q;
        len_d     = len_q;
        beat_d    = beat_q;
        burst_d   = burst_q;
        err_d     = err_q;
        fresh_d   = 1'b0;
        rdata_d   = fresh_q ? rd_now : rdata_q;
        mem_en_o  = 1'b0;
        mem_we_o  = '0;
        case (state_q)
            IDLE: begin
                if (grant_w || grant_r) begin
                    state_d   = grant_w ? WR_DATA : RD_REQ;
                    prio_wr_d = (axi.awvalid && axi.arvalid) ? !prio_wr_q : prio_wr_q;
                    id_d      = grant_w ? axi.awid : axi.arid;
                    addr_d    = sel_addr;
                    len_d     = sel_len;
                    beat_d    = '0;
                    burst_d   = sel_burst == FIXED ? FIXED : (sel_burst == WRAP && wrap_ok) ? WRAP : INCR;
                    err_d     = sel_burst == 2'b11 || (sel_burst == WRAP && !wrap_ok);
                end
            end
            WR_DATA: begin
                if (axi.wvalid) begin
                    mem_en_o = !oor;
                    mem_we_o = oor ? '0 : axi.wstrb;
                    err_d    = err_q || oor || (axi.wlast != last);
                    addr_d   = next_addr;
                    beat_d   = beat_q + 8'd1;
                    state_d  = last ? WR_RESP : WR_DATA;
                end
            end
            WR_RESP: state_d = axi.bready ? IDLE : WR_RESP;
            RD_REQ: begin
                mem_en_o = !oor;
                fresh_d  = 1'b1;
                state_d  = RD_DATA;
            end
            RD_DATA: begin
                if (axi.rready) begin
                    state_d = last ? IDLE : RD_REQ;
                    addr_d  = last ? addr_q : next_addr;
                    beat_d  = beat_q + 8'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and burst context registers; reset abandons any burst in flight
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            prio_wr_q <= 1'b1;
            id_q      <= '0;
            addr_q    <= '0;
            len_q     <= '0;
            beat_q    <= '0;
            burst_q   <= INCR;
            err_q     <= 1'b0;
            fresh_q   <= 1'b0;
            rdata_q   <= '0;
        end else begin
            state_q   <= state_d;
            prio_wr_q <= prio_wr_d;
            id_q      <= id_d;
            addr_q    <= addr_d;
            len_q     <= len_d;
            beat_q    <= beat_d;
            burst_q   <= burst_d;
            err_q     <= err_d;
            fresh_q   <= fresh_d;
            rdata_q   <= rdata_d;
        end
    end
endmodule

// File: tb/tb_axi_sram_ctrl.sv
// tb_axi_sram_ctrl: directed and random AXI bursts checked against a byte-address reference model
module tb_axi_sram_ctrl;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mem_en;
    logic [3:0]  mem_we;
    logic [9:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata = '0;

    axi_sram_ctrl_if #(.ID_W(4), .ADDR_W(32), .DATA_BYTES(4)) bus ();

    axi_sram_ctrl #(.MEM_ADDR_WIDTH(10), .DATA_BYTES(4), .ID_W(4), .ADDR_W(32)) dut (
        .clk_i(clk), .rst_i(rst), .axi(bus.slave), .mem_en_o(mem_en), .mem_we_o(mem_we),
        .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata)
    );

    always #5 clk = ~clk;

    logic [31:0] sram    [1024];
    logic [31:0] ref_mem [1024];
    logic        fill = 1'b0;
    int          fill_lo = 0, fill_hi = 0;

    // SRAM macro model with a bench-side preload port
    always @(posedge clk) begin
        if (fill) begin
            for (int i = fill_lo; i <= fill_hi; i++) sram[i] <= ref_mem[i];
        end else if (mem_en) begin
            if (mem_we != 4'h0) begin
                for (int b = 0; b < 4; b++) if (mem_we[b]) sram[mem_addr][8*b+:8] <= mem_wdata[8*b+:8];
            end else begin
                mem_rdata <= sram[mem_addr];
            end
        end
    end

    int         cyc = 0, en_cnt = 0, we_cnt = 0;
    logic [9:0] alog[$];

    // Cycle counter and SRAM access monitor
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (mem_en) begin
            en_cnt <= en_cnt + 1;
            alog.push_back(mem_addr);
        end
        if (mem_we != 4'h0) we_cnt <= we_cnt + 1;
    end

    int n_chk = 0, n_fail = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic berr(input logic [7:0] len, input logic [1:0] burst);
        return burst == 2'b11 || (burst == 2'b10 && !(len inside {8'd1, 8'd3, 8'd7, 8'd15}));
    endfunction

    function automatic logic oor(input logic [31:0] a);
        return a >= 32'h1000;
    endfunction

    // Byte address of beat i from the AXI burst rules
    function automatic logic [31:0] baddr(input logic [31:0] a, input logic [7:0] len, input logic [1:0] burst, input int i);
        logic [31:0] s, size;
        s = a & ~32'h3;
        size = (32'(len) + 32'd1) * 32'd4;
        if (burst == 2'b00) return s;
        if (burst == 2'b10 && !berr(len, burst)) return s - s % size + (s % size + 32'(4 * i)) % size;
        return (s & 32'hFFFF_F000) | ((s + 32'(4 * i)) % 32'h1000);
    endfunction

    logic [31:0] wd [16];
    logic [3:0]  ws [16];
    logic [31:0] rd [16];
    logic [1:0]  rr [16];
    logic        rl [16];
    int          bad_last = -1;
    int          lat_b = 0, lat_r = 0;
    logic [1:0]  last_bresp = 2'b11;

    task automatic axi_write(input logic [3:0] id, input logic [31:0] a, input logic [7:0] len,
                             input logic [1:0] burst, input int stop_after);
        logic        err;
        logic [31:0] ba;
        int          t, wcyc;
        err = berr(len, burst);
        wcyc = 0;
        bus.awid = id; bus.awaddr = a; bus.awlen = len; bus.awburst = burst; bus.awvalid = 1'b1;
        t = 0;
        #1;
        while (!bus.awready && t < 50) begin @(negedge clk); #1; t++; end
        if (t == 50) begin check("aw_timeout", 0, 1); bus.awvalid = 1'b0; return; end
        @(negedge clk);
        bus.awvalid = 1'b0;
        for (int i = 0; i <= int'(len); i++) begin
            if (i == stop_after) return;
            ba = baddr(a, len, burst, i);
            bus.wdata = wd[i]; bus.wstrb = ws[i]; bus.wlast = (i == int'(len)) ^ (i == bad_last); bus.wvalid = 1'b1;
            t = 0;
            #1;
            while (!bus.wready && t < 50) begin @(negedge clk); #1; t++; end
            if (t == 50) begin check("w_timeout", 0, 1); bus.wvalid = 1'b0; return; end
            if (i == bad_last) err = 1'b1;
            if (oor(ba)) err = 1'b1;
            else for (int b = 0; b < 4; b++) if (ws[i][b]) ref_mem[ba[11:2]][8*b+:8] = wd[i][8*b+:8];
            wcyc = cyc;
            @(negedge clk);
            bus.wvalid = 1'b0; bus.wlast = 1'b0;
        end
        bus.bready = 1'b1;
        t = 0;
        #1;
        while (!bus.bvalid && t < 50) begin @(negedge clk); #1; t++; end
        if (t == 50) begin check("b_timeout", 0, 1); bus.bready = 1'b0; return; end
        lat_b = cyc - wcyc;
        last_bresp = bus.bresp;
        check("bresp", 32'(bus.bresp), err ? 32'd2 : 32'd0);
        check("bid", 32'(bus.bid), 32'(id));
        @(negedge clk);
        bus.bready = 1'b0;
    endtask

    task automatic axi_read(input logic [3:0] id, input logic [31:0] a, input logic [7:0] len,
                            input logic [1:0] burst, input int stall_beat, input int stall_n);
        logic [31:0] ba, sd;
        logic        sl;
        int          t, arc, se;
        bus.arid = id; bus.araddr = a; bus.arlen = len; bus.arburst = burst; bus.arvalid = 1'b1;
        bus.rready = 1'b0;
        t = 0;
        #1;
        while (!bus.arready && t < 50) begin @(negedge clk); #1; t++; end
        if (t == 50) begin check("ar_timeout", 0, 1); bus.arvalid = 1'b0; return; end
        arc = cyc;
        @(negedge clk);
        bus.arvalid = 1'b0;
        for (int i = 0; i <= int'(len); i++) begin
            t = 0;
            #1;
            while (!bus.rvalid && t < 50) begin @(negedge clk); #1; t++; end
            if (t == 50) begin check("r_timeout", 0, 1); return; end
            if (i == 0) lat_r = cyc - arc;
            ba = baddr(a, len, burst, i);
            rd[i] = bus.rdata; rr[i] = bus.rresp; rl[i] = bus.rlast;
            check("rdata", bus.rdata, oor(ba) ? 32'd0 : ref_mem[ba[11:2]]);
            check("rresp", 32'(bus.rresp), (oor(ba) || berr(len, burst)) ? 32'd2 : 32'd0);
            check("rlast", 32'(bus.rlast), 32'(i == int'(len)));
            check("rid", 32'(bus.rid), 32'(id));
            if (i == stall_beat) begin
                sd = bus.rdata; sl = bus.rlast; se = en_cnt;
                repeat (stall_n) begin
                    @(negedge clk);
                    #1;
                    check("stall_rvalid", 32'(bus.rvalid), 32'd1);
                    check("stall_rdata", bus.rdata, sd);
                    check("stall_rlast", 32'(bus.rlast), 32'(sl));
                    check("stall_rid", 32'(bus.rid), 32'(id));
                    check("stall_mem_en", 32'(en_cnt), 32'(se));
                end
            end
            bus.rready = 1'b1;
            @(negedge clk);
            bus.rready = 1'b0;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] ra;
        logic [7:0]  rlen;
        logic [1:0]  rbst;
        int          s0, we0;
        int          exp_wrap [4];
        exp_wrap = '{3, 0, 1, 2};
        bus.awid = '0; bus.awaddr = '0; bus.awlen = '0; bus.awburst = '0; bus.awvalid = 1'b0;
        bus.wdata = '0; bus.wstrb = '0; bus.wlast = 1'b0; bus.wvalid = 1'b0; bus.bready = 1'b0;
        bus.arid = '0; bus.araddr = '0; bus.arlen = '0; bus.arburst = '0; bus.arvalid = 1'b0;
        bus.rready = 1'b0;
        for (int i = 0; i < 1024; i++) ref_mem[i] = $urandom;
        fill_lo = 0; fill_hi = 1023; fill = 1'b1;
        repeat (3) @(negedge clk);
        fill = 1'b0;
        #1;
        check("rst_awready", 32'(bus.awready), 0);
        check("rst_arready", 32'(bus.arready), 0);
        check("rst_wready", 32'(bus.wready), 0);
        check("rst_bvalid", 32'(bus.bvalid), 0);
        check("rst_rvalid", 32'(bus.rvalid), 0);
        check("rst_mem_en", 32'(mem_en), 0);
        check("rst_mem_we", 32'(mem_we), 0);
        @(negedge clk);
        rst = 1'b0;

        // Contention straight after reset: write first, then the waiting read
        bus.awid = 4'd1; bus.awaddr = 32'h010; bus.awlen = 8'd0; bus.awburst = 2'b01; bus.awvalid = 1'b1;
        bus.arid = 4'd2; bus.araddr = 32'h010; bus.arlen = 8'd0; bus.arburst = 2'b01; bus.arvalid = 1'b1;
        #1;
        check("arb1_awready", 32'(bus.awready), 1);
        check("arb1_arready", 32'(bus.arready), 0);
        wd[0] = 32'hDEADBEEF; ws[0] = 4'hF;
        axi_write(4'd1, 32'h010, 8'd0, 2'b01, -1);
        check("single_bresp", 32'(last_bresp), 0);
        check("bvalid_latency", 32'(lat_b), 1);
        axi_read(4'd2, 32'h010, 8'd0, 2'b01, -1, 0);
        check("single_rdata", rd[0], 32'hDEADBEEF);
        check("single_rlast", 32'(rl[0]), 1);
        check("single_rresp", 32'(rr[0]), 0);
        check("rvalid_latency", 32'(lat_r), 2);

        // Second contention: the pointer now favours the read
        bus.awid = 4'd3; bus.awaddr = 32'h014; bus.awlen = 8'd0; bus.awburst = 2'b01; bus.awvalid = 1'b1;
        bus.arid = 4'd4; bus.araddr = 32'h014; bus.arlen = 8'd0; bus.arburst = 2'b01; bus.arvalid = 1'b1;
        #1;
        check("arb2_awready", 32'(bus.awready), 0);
        check("arb2_arready", 32'(bus.arready), 1);
        axi_read(4'd4, 32'h014, 8'd0, 2'b01, -1, 0);
        wd[0] = 32'h1234_5678; ws[0] = 4'hF;
        axi_write(4'd3, 32'h014, 8'd0, 2'b01, -1);

        // INCR len3 over a preloaded all-ones region with a half-word strobe on beat 2
        for (int i = 8; i < 12; i++) ref_mem[i] = 32'hFFFF_FFFF;
        fill_lo = 8; fill_hi = 11; fill = 1'b1;
        @(negedge clk);
        fill = 1'b0;
        for (int i = 0; i < 4; i++) begin wd[i] = 32'(i + 1); ws[i] = (i == 2) ? 4'h3 : 4'hF; end
        axi_write(4'd5, 32'h020, 8'd3, 2'b01, -1);
        axi_read(4'd6, 32'h020, 8'd3, 2'b01, -1, 0);
        check("incr_b0", rd[0], 32'h1);
        check("incr_b1", rd[1], 32'h2);
        check("incr_b2", rd[2], 32'hFFFF_0003);
        check("incr_b3", rd[3], 32'h4);
        check("incr_rlast", {28'd0, rl[3], rl[2], rl[1], rl[0]}, 32'b1000);

        // WRAP len3 from word 3 wraps to 0; WRAP len2 degrades to INCR with SLVERR
        s0 = alog.size();
        axi_read(4'd7, 32'h00C, 8'd3, 2'b10, -1, 0);
        check("wrap_count", 32'(alog.size() - s0), 4);
        for (int i = 0; i < 4; i++) check("wrap_addr", 32'(alog[s0 + i]), 32'(exp_wrap[i]));
        s0 = alog.size();
        axi_read(4'd8, 32'h020, 8'd2, 2'b10, -1, 0);
        for (int i = 0; i < 3; i++) check("wrap2_addr", 32'(alog[s0 + i]), 32'(8 + i));
        for (int i = 0; i < 3; i++) check("wrap2_rresp", 32'(rr[i]), 2);

        // R channel held for 5 cycles on beat 1
        axi_read(4'd9, 32'h020, 8'd1, 2'b01, 1, 5);

        // Out-of-range write never strobes the SRAM
        we0 = we_cnt;
        wd[0] = 32'hCAFE_F00D; ws[0] = 4'hF;
        axi_write(4'd10, 32'h1000_0000, 8'd0, 2'b01, -1);
        check("oor_bresp", 32'(last_bresp), 2);
        check("oor_we", 32'(we_cnt - we0), 0);

        // Reset after two beats of a len3 write
        we0 = we_cnt;
        for (int i = 0; i < 4; i++) begin wd[i] = $urandom; ws[i] = 4'hF; end
        axi_write(4'd11, 32'h100, 8'd3, 2'b01, 2);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        repeat (6) begin
            @(negedge clk);
            #1;
            check("abort_bvalid", 32'(bus.bvalid), 0);
        end
        check("abort_wready", 32'(bus.wready), 0);
        check("abort_we_count", 32'(we_cnt - we0), 2);
        axi_read(4'd12, 32'h100, 8'd3, 2'b01, -1, 0);

        // Random bursts against the reference model
        for (int n = 0; n < 40; n++) begin
            ra = ($urandom_range(0, 1023) << 2) | 32'($urandom_range(0, 3));
            if ($urandom_range(0, 9) == 0) ra = ra | (32'h1000 << $urandom_range(0, 19));
            rlen = 8'($urandom_range(0, 7));
            rbst = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
            bad_last = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, int'(rlen))) : -1;
            if ($urandom_range(0, 1) == 1) begin
                for (int i = 0; i < 16; i++) begin wd[i] = $urandom; ws[i] = 4'($urandom_range(0, 15)); end
                axi_write(4'($urandom_range(0, 15)), ra, rlen, rbst, -1);
            end else begin
                axi_read(4'($urandom_range(0, 15)), ra, rlen, rbst, int'($urandom_range(0, int'(rlen))), int'($urandom_range(0, 3)));
            end
            bad_last = -1;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
